slave_port: RTL

Responder end of the serial system bus; the counterpart of the bus master port on the far side of the interconnect. Receives the bit-serial 16-bit address and write data, decodes the 4-bit device ID, returns the ack handshake, and drives serial read data back. Presents a parallel, single-cycle-strobe interface to a local synchronous memory or register file.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_shift_reg.sv | 28 ++
 rtl/slave_port.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the serial system bus responder.
package bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_1,
        ST_ACK,
        ST_ADDR_2,
        ST_WR_DATA,
        ST_WRITE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DATA
    } slave_state_t;

    localparam int ADDR1_BITS = 5;
    localparam int ADDR_BITS  = 16;
    localparam int DATA_BITS  = 8;
    localparam int ID_W       = 4;

    localparam logic MODE_WR = 1'b1;
    localparam logic MODE_RD = 1'b0;

endpackage

// File: rtl/bus_shift_reg.sv
// Shift register: serial-in/parallel-out and parallel-load/serial-out, MSB first.
module bus_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         serial_in,
    input  logic         load_en,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         serial_out
);

    // A parallel load wins over a shift in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load_en) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {data[W-2:0], serial_in};
        end
    end

    assign serial_out = data[W-1];

endmodule

// File: rtl/slave_port.sv
// Serial bus responder: decodes the device ID, returns ack, drives local memory strobes.
// Defining SLAVE_BACKPRESSURE_EN adds s_busy, which stalls bus handshakes and strobes.
module slave_port
    import bus_pkg::*;
#(
    parameter logic [ID_W-1:0] SLAVE_ID   = 4'h0,
    parameter int              ADDR_W     = 12,
    parameter int              MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              wr_bus,
    output logic              rd_bus,
    output logic              ack,
    input  logic              master_valid,
    output logic              slave_ready,
    input  logic              master_ready,
    output logic              slave_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wr_data,
    output logic              s_wr_en,
    output logic              s_rd_en,
    input  logic [7:0]        s_rd_data,
`ifdef SLAVE_BACKPRESSURE_EN
    input  logic              s_busy,
`endif
    output slave_state_t      dbg_state
);

    localparam logic [4:0] ADDR1_LAST = 5'(ADDR1_BITS - 1);
    localparam logic [4:0] ADDR2_LAST = 5'(ADDR_BITS - ADDR1_BITS - 1);
    localparam logic [4:0] DATA_LAST  = 5'(DATA_BITS - 1);
    localparam logic [4:0] WAIT_LAST  = 5'(MEM_RD_LAT - 1);

    slave_state_t         state;
    logic [4:0]           cnt;
    logic                 mode_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 ack_q;
    logic                 wr_q;
    logic                 rd_q;
    logic                 busy;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 addr_shift;
    logic                 wdata_shift;
    logic                 tx_load;
    logic                 tx_shift;
    logic                 tx_msb;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] addr_next;
    logic [DATA_BITS-1:0] tx_data_unused;
    logic                 addr_msb_unused;
    logic                 wdata_msb_unused;
    logic                 unused_bits;

`ifdef SLAVE_BACKPRESSURE_EN
    assign busy = s_busy;
`else
    assign busy = 1'b0;
`endif

    // A bit moves inbound on master_valid & slave_ready and outbound on
    // slave_valid & master_ready, both sampled at the rising clock edge.
    assign slave_ready = ready_q & ~busy;
    assign slave_valid = valid_q & ~busy;
    assign in_xfer     = master_valid & slave_ready;
    assign out_xfer    = slave_valid & master_ready;

    assign ack       = ack_q;
    assign s_wr_en   = wr_q & ~busy;
    assign s_rd_en   = rd_q & ~busy;
    assign rd_bus    = tx_msb & (state == ST_RD_DATA);
    assign dbg_state = state;

    assign addr_next   = {addr_q[ADDR_BITS-2:0], wr_bus};
    assign addr_shift  = in_xfer & (state != ST_WR_DATA);
    assign wdata_shift = in_xfer & (state == ST_WR_DATA);
    assign tx_load     = (state == ST_RD_WAIT) && (cnt == WAIT_LAST);
    assign tx_shift    = out_xfer & (state == ST_RD_DATA);
    assign unused_bits = ^{addr_q[ADDR_BITS-1], addr_next};

    bus_shift_reg #(.W(ADDR_BITS)) u_addr_sr (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (addr_shift),
        .serial_in  (wr_bus),
        .load_en    (1'b0),
        .load_data  ('0),
        .data       (addr_q),
        .serial_out (addr_msb_unused)
    );

    bus_shift_reg #(.W(DATA_BITS)) u_wdata_sr (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (wdata_shift),
        .serial_in  (wr_bus),
        .load_en    (1'b0),
        .load_data  ('0),
        .data       (s_wr_data),
        .serial_out (wdata_msb_unused)
    );

    bus_shift_reg #(.W(DATA_BITS)) u_tx_sr (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (tx_shift),
        .serial_in  (1'b0),
        .load_en    (tx_load),
        .load_data  (s_rd_data),
        .data       (tx_data_unused),
        .serial_out (tx_msb)
    );

    // Handshake flags are registered and set on entry to the state that drives them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            s_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (in_xfer) begin
                        mode_q <= mode;
                        cnt    <= 5'd1;
                        state  <= ST_ADDR_1;
                    end
                end
                ST_ADDR_1: begin
                    if (in_xfer) begin
                        if (cnt == ADDR1_LAST) begin
                            // addr_q[3:0] already holds addr[15:12] as the 5th bit shifts in
                            ack_q   <= (addr_q[ID_W-1:0] == SLAVE_ID);
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_ACK;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (out_xfer) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ack_q ? ST_ADDR_2 : ST_IDLE;
                    end
                end
                ST_ADDR_2: begin
                    if (in_xfer) begin
                        if (cnt == ADDR2_LAST) begin
                            s_addr <= addr_next[ADDR_W-1:0];
                            cnt    <= '0;
                            if (mode_q == MODE_WR) begin
                                state <= ST_WR_DATA;
                            end else begin
                                ready_q <= 1'b0;
                                rd_q    <= 1'b1;
                                state   <= ST_RD_REQ;
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (in_xfer) begin
                        if (cnt == DATA_LAST) begin
                            ready_q <= 1'b0;
                            wr_q    <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_WRITE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!busy) begin
                        wr_q    <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (!busy) begin
                        rd_q  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        valid_q <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_RD_DATA;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_RD_DATA: begin
                    if (out_xfer) begin
                        if (cnt == DATA_LAST) begin
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    ack_q   <= 1'b0;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    cnt     <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
